// File: rtl/ip_ascii8_psram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : ip_ascii8_psram_bridge_bus_if / ip_ascii8_psram_bridge_psram_if
// Brief    : MSX bus-decoder side and PSRAM-channel side of the ASCII8 bridge
// Revision : 1.0 - initial release
// ============================================================================

interface ip_ascii8_psram_bridge_bus_if;
    logic [15:0] bus_address;
    logic        bus_memory;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_write_data;
    logic [7:0]  bus_read_data;
    logic        bus_read_ready;
    logic        n_wait;

    // master = bus decoder, slave = bridge
    modport master (
        output bus_address, bus_memory, bus_read, bus_write, bus_write_data,
        input  bus_read_data, bus_read_ready, n_wait
    );
    modport slave (
        input  bus_address, bus_memory, bus_read, bus_write, bus_write_data,
        output bus_read_data, bus_read_ready, n_wait
    );
endinterface

interface ip_ascii8_psram_bridge_psram_if;
    logic        psram_rd;
    logic        psram_wr;
    logic        psram_busy;
    logic [23:0] psram_address;
    logic [7:0]  psram_wdata;
    logic [7:0]  psram_rdata;
    logic        psram_rdata_en;

    // master = bridge, slave = PSRAM controller channel
    modport master (
        output psram_rd, psram_wr, psram_address, psram_wdata,
        input  psram_busy, psram_rdata, psram_rdata_en
    );
    modport slave (
        input  psram_rd, psram_wr, psram_address, psram_wdata,
        output psram_busy, psram_rdata, psram_rdata_en
    );
endinterface

`default_nettype wire

// File: rtl/ip_ascii8_psram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ip_ascii8_psram_bridge
// Brief    : ASCII8 MegaROM mapper translating MSX bus cycles into PSRAM
//            single-byte requests, holding the CPU with n_wait meanwhile.
// Revision : 1.0 - initial release
// ============================================================================

module ip_ascii8_psram_bridge #(
    parameter logic [23:0] BASE_ADDR    = 24'h000000,
    parameter bit          RAM_WRITE_EN = 1'b0,
    parameter int unsigned TIMEOUT      = 255
) (
    input wire logic                       clk,
    input wire logic                       n_reset,
    ip_ascii8_psram_bridge_bus_if.slave    bus,
    ip_ascii8_psram_bridge_psram_if.master psram
);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [7:0] c_timeout  = 8'(TIMEOUT);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [7:0]  r_bank [4];
    logic        r_is_read;
    logic [23:0] r_psram_address;
    logic [7:0]  r_psram_wdata;
    logic        r_psram_rd;
    logic        r_psram_wr;
    logic [7:0]  r_timer;
    logic [7:0]  r_read_data;
    logic        r_read_ready;

    logic        w_accept, w_is_rd, w_is_wr, w_mapped, w_regwin;
    logic        w_start, w_reg_upd, w_timeout, w_done;
    logic [1:0]  w_page;
    logic [23:0] w_map_addr;
    logic        w_n_wait, w_issue_rd, w_issue_wr;

    // Pages 4000h-BFFFh have A15 != A14; page index wraps so 4000h maps to bank0.
    assign w_accept   = (r_state == c_st_idle) && bus.bus_memory;
    assign w_is_rd    = bus.bus_read;
    assign w_is_wr    = bus.bus_write && !bus.bus_read;
    assign w_mapped   = bus.bus_address[15] ^ bus.bus_address[14];
    assign w_regwin   = (bus.bus_address[15:13] == 3'b011);
    assign w_page     = bus.bus_address[14:13] - 2'd2;
    assign w_map_addr = BASE_ADDR + {3'b000, r_bank[w_page], bus.bus_address[12:0]};
    assign w_start    = w_accept && w_mapped &&
                        (w_is_rd || (w_is_wr && !w_regwin && RAM_WRITE_EN));
    assign w_reg_upd  = w_accept && w_is_wr && w_regwin;

    // Write completion skips the request cycle and the following one, since
    // the controller may raise busy one cycle late.
    assign w_timeout  = (r_timer == c_timeout);
    assign w_done     = r_is_read ? psram.psram_rdata_en
                                  : ((r_timer >= 8'd2) && !psram.psram_busy);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_start)              w_next = c_st_issue;
            c_st_issue: if (!psram.psram_busy)    w_next = c_st_wait;
            c_st_wait:  if (w_done || w_timeout)  w_next = c_st_idle;
            default:                              w_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_n_wait   = 1'b1;
        w_issue_rd = 1'b0;
        w_issue_wr = 1'b0;
        case (r_state)
            c_st_issue: begin
                w_n_wait   = 1'b0;
                w_issue_rd = !psram.psram_busy && r_is_read;
                w_issue_wr = !psram.psram_busy && !r_is_read;
            end
            c_st_wait:  w_n_wait = 1'b0;
            default:    w_n_wait = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_bank[0]       <= 8'd0;
            r_bank[1]       <= 8'd1;
            r_bank[2]       <= 8'd2;
            r_bank[3]       <= 8'd3;
            r_is_read       <= 1'b0;
            r_psram_address <= 24'd0;
            r_psram_wdata   <= 8'd0;
            r_psram_rd      <= 1'b0;
            r_psram_wr      <= 1'b0;
            r_timer         <= 8'd0;
            r_read_data     <= 8'hFF;
            r_read_ready    <= 1'b0;
        end else begin
            r_psram_rd   <= w_issue_rd;
            r_psram_wr   <= w_issue_wr;
            r_read_ready <= 1'b0;
            if (w_reg_upd) begin
                r_bank[bus.bus_address[12:11]] <= bus.bus_write_data;
            end
            if (w_start) begin
                r_is_read       <= w_is_rd;
                r_psram_address <= w_map_addr;
                if (w_is_wr) begin
                    r_psram_wdata <= bus.bus_write_data;
                end
            end
            if (r_state != c_st_wait) begin
                r_timer <= 8'd0;
            end else if (!w_timeout) begin
                r_timer <= r_timer + 8'd1;
            end
            if ((r_state == c_st_wait) && r_is_read) begin
                if (psram.psram_rdata_en) begin
                    r_read_data  <= psram.psram_rdata;
                    r_read_ready <= 1'b1;
                end else if (w_timeout) begin
                    r_read_data  <= 8'hFF;
                    r_read_ready <= 1'b1;
                end
            end
        end
    end

    assign bus.n_wait           = w_n_wait;
    assign bus.bus_read_data    = r_read_data;
    assign bus.bus_read_ready   = r_read_ready;
    assign psram.psram_rd       = r_psram_rd;
    assign psram.psram_wr       = r_psram_wr;
    assign psram.psram_address  = r_psram_address;
    assign psram.psram_wdata    = r_psram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ip_ascii8_psram_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ip_ascii8_psram_bridge
// Brief    : Three bridge instances (different BASE_ADDR / RAM_WRITE_EN) share
//            one bus stream and are checked against an arithmetic mapper model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_ip_ascii8_psram_bridge;
    localparam int NDUT    = 3;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] bus_address;
    logic        bus_memory, bus_read, bus_write;
    logic [7:0]  bus_write_data;
    logic        psram_busy;
    logic [7:0]  psram_rdata;
    logic        psram_rdata_en;

    logic [7:0]  rd_data  [NDUT];
    logic        rd_ready [NDUT];
    logic        n_wait   [NDUT];
    logic        p_rd     [NDUT];
    logic        p_wr     [NDUT];
    logic [23:0] p_addr   [NDUT];
    logic [7:0]  p_wdata  [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ip_ascii8_psram_bridge_bus_if   bif ();
        ip_ascii8_psram_bridge_psram_if pif ();
        assign bif.bus_address    = bus_address;
        assign bif.bus_memory     = bus_memory;
        assign bif.bus_read       = bus_read;
        assign bif.bus_write      = bus_write;
        assign bif.bus_write_data = bus_write_data;
        assign pif.psram_busy     = psram_busy;
        assign pif.psram_rdata    = psram_rdata;
        assign pif.psram_rdata_en = psram_rdata_en;
        assign rd_data[g]  = bif.bus_read_data;
        assign rd_ready[g] = bif.bus_read_ready;
        assign n_wait[g]   = bif.n_wait;
        assign p_rd[g]     = pif.psram_rd;
        assign p_wr[g]     = pif.psram_wr;
        assign p_addr[g]   = pif.psram_address;
        assign p_wdata[g]  = pif.psram_wdata;
        ip_ascii8_psram_bridge #(
            .BASE_ADDR    ((g == 0) ? 24'h000000 : (g == 1) ? 24'h200000 : 24'hFFFFF0),
            .RAM_WRITE_EN (g == 1),
            .TIMEOUT      (TIMEOUT)
        ) u_dut (
            .clk     (clk),
            .n_reset (n_reset),
            .bus     (bif.slave),
            .psram   (pif.master)
        );
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
        end
    endtask

    // Reference model: banks and address arithmetic straight from the mapper rules
    int bank_m [4];

    function automatic logic [23:0] base_of(input int g);
        return (g == 0) ? 24'h000000 : (g == 1) ? 24'h200000 : 24'hFFFFF0;
    endfunction

    function automatic bit rwe_of(input int g);
        return (g == 1);
    endfunction

    function automatic logic [23:0] model_addr(input int g, input logic [15:0] a);
        int     p;
        longint sum;
        p   = (int'(a) - 'h4000) / 'h2000;
        sum = longint'(base_of(g)) + longint'(bank_m[p]) * 8192 + longint'(int'(a) % 8192);
        return 24'(sum % (longint'(1) << 24));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) bank_m[i] = i;
    endtask

    // Protocol watcher: rd/wr never together, never two cycles in a row
    int   viol [NDUT] = '{default: 0};
    logic prev_rd [NDUT] = '{default: 1'b0};
    logic prev_wr [NDUT] = '{default: 1'b0};
    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (p_rd[g] === 1'b1 && p_wr[g] === 1'b1) viol[g]++;
            if ((p_rd[g] === 1'b1 && prev_rd[g] === 1'b1) ||
                (p_wr[g] === 1'b1 && prev_wr[g] === 1'b1)) viol[g]++;
            prev_rd[g] = p_rd[g];
            prev_wr[g] = p_wr[g];
        end
    end

    int          nrd [NDUT], nwr [NDUT], req_cycle [NDUT], first_low [NDUT];
    int          release_c [NDUT], nready [NDUT], ready_cycle [NDUT];
    logic [23:0] req_addr [NDUT];
    logic [7:0]  req_wdata [NDUT], ready_val [NDUT];

    // One bus access, with a PSRAM responder: busy high for busy_pre cycles,
    // rdata_en dly cycles after psram_rd, busy pulse two cycles after psram_wr.
    task automatic access(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] wd,
                          input logic [7:0] rdat, input int dly, input int busy_pre,
                          input bit respond, input int extra_at);
        int rd_seen, wr_seen, idle_run;
        bit done, any_rd, any_wr, all_high;
        rd_seen = -1; wr_seen = -1; idle_run = 0; done = 0;
        for (int g = 0; g < NDUT; g++) begin
            nrd[g] = 0; nwr[g] = 0; req_cycle[g] = -1; first_low[g] = -1;
            release_c[g] = -1; nready[g] = 0; ready_cycle[g] = -1;
            req_addr[g] = '0; req_wdata[g] = '0; ready_val[g] = '0;
        end
        @(posedge clk); #1;
        bus_address = a; bus_read = rd; bus_write = wr; bus_write_data = wd; bus_memory = 1'b1;
        psram_busy = (busy_pre > 0); psram_rdata_en = 1'b0; psram_rdata = rdat;
        for (int c = 1; c <= 600 && !done; c++) begin
            @(posedge clk); #1;
            bus_memory     = (c == extra_at);
            psram_busy     = (c < busy_pre) || (wr_seen >= 0 && c >= wr_seen + 2 && c <= wr_seen + 3);
            psram_rdata_en = respond && rd_seen >= 0 && c == rd_seen + dly;
            #1;
            any_rd = 0; any_wr = 0; all_high = 1;
            for (int g = 0; g < NDUT; g++) begin
                if (p_rd[g] || p_wr[g]) begin
                    if (p_rd[g]) nrd[g]++;
                    if (p_wr[g]) nwr[g]++;
                    req_cycle[g] = c; req_addr[g] = p_addr[g]; req_wdata[g] = p_wdata[g];
                end
                if (!n_wait[g] && first_low[g] < 0) first_low[g] = c;
                if (n_wait[g] && first_low[g] >= 0 && release_c[g] < 0) release_c[g] = c;
                if (rd_ready[g]) begin nready[g]++; ready_cycle[g] = c; ready_val[g] = rd_data[g]; end
                any_rd |= p_rd[g]; any_wr |= p_wr[g]; all_high &= n_wait[g];
            end
            if (any_rd && rd_seen < 0) rd_seen = c;
            if (any_wr && wr_seen < 0) wr_seen = c;
            idle_run = all_high ? idle_run + 1 : 0;
            if (idle_run >= 3 && c >= busy_pre && c > extra_at &&
                !(respond && rd_seen >= 0 && c < rd_seen + dly)) done = 1;
        end
        if (!done) check("access_bound", 0, 32'(done), 32'd1);
        bus_memory = 1'b0; bus_read = 1'b0; bus_write = 1'b0;
        psram_busy = 1'b0; psram_rdata_en = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [15:0] a, input logic rd, input logic wr,
                          input logic [7:0] wd, input logic [7:0] rdat, input bit respond, input int busy_pre);
        bit is_rd, is_wr, mapped, regwin, exp_req;
        is_rd  = rd;
        is_wr  = wr && !rd;
        mapped = (a >= 16'h4000) && (a <= 16'hBFFF);
        regwin = (a >= 16'h6000) && (a <= 16'h7FFF);
        for (int g = 0; g < NDUT; g++) begin
            exp_req = mapped && (is_rd || (is_wr && !regwin && rwe_of(g)));
            check({tag, ".rd_pulses"}, g, nrd[g], 32'(exp_req && is_rd));
            check({tag, ".wr_pulses"}, g, nwr[g], 32'(exp_req && is_wr));
            if (exp_req) begin
                check({tag, ".address"}, g, 32'(req_addr[g]), 32'(model_addr(g, a)));
                check({tag, ".wait_start"}, g, first_low[g], 32'd1);
                check({tag, ".req_after_busy"}, g, 32'(req_cycle[g] > busy_pre), 32'd1);
                if (is_rd) begin
                    check({tag, ".ready_count"}, g, nready[g], 32'd1);
                    check({tag, ".read_data"}, g, 32'(ready_val[g]), respond ? 32'(rdat) : 32'hFF);
                    check({tag, ".release_at_ready"}, g, release_c[g], ready_cycle[g]);
                end else begin
                    check({tag, ".wdata"}, g, 32'(req_wdata[g]), 32'(wd));
                    check({tag, ".release_after_busy"}, g, 32'(release_c[g] > req_cycle[g] + 3), 32'd1);
                end
            end else begin
                check({tag, ".no_wait"}, g, first_low[g], 32'hFFFF_FFFF);
                check({tag, ".no_ready"}, g, nready[g], 32'd0);
            end
        end
        if (is_wr && regwin) bank_m[(int'(a) - 'h6000) / 'h800] = int'(wd);
    endtask

    typedef struct {
        logic [15:0] a;
        logic        rd;
        logic        wr;
        logic [7:0]  wd;
        logic [7:0]  rdat;
        int          dly;
        int          busy_pre;
        bit          exp_req0;
        logic [23:0] exp_addr0;
    } vec_t;

    vec_t vecs [16];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen, bad;
        logic [15:0] ra;
        int   kind;

        // Hand-derived expectations for dut0 (BASE 000000h, RAM writes dropped)
        vecs[0]  = '{16'h4000, 1, 0, 8'h00, 8'hA5, 5, 0, 1, 24'h000000};
        vecs[1]  = '{16'h7000, 0, 1, 8'h3C, 8'h00, 1, 0, 0, 24'h000000};
        vecs[2]  = '{16'h9FFF, 1, 0, 8'h00, 8'h11, 2, 0, 1, 24'h079FFF};
        vecs[3]  = '{16'h7800, 0, 1, 8'hFF, 8'h00, 1, 0, 0, 24'h000000};
        vecs[4]  = '{16'hBFFF, 1, 0, 8'h00, 8'h22, 3, 1, 1, 24'h1FFFFF};
        vecs[5]  = '{16'h7800, 0, 1, 8'h00, 8'h00, 1, 0, 0, 24'h000000};
        vecs[6]  = '{16'hA005, 1, 0, 8'h00, 8'h33, 1, 0, 1, 24'h000005};
        vecs[7]  = '{16'h8000, 0, 1, 8'h5A, 8'h00, 1, 3, 0, 24'h000000};
        vecs[8]  = '{16'h2000, 1, 0, 8'h00, 8'h00, 1, 0, 0, 24'h000000};
        vecs[9]  = '{16'h4000, 0, 0, 8'h00, 8'h00, 1, 0, 0, 24'h000000};
        vecs[10] = '{16'h6000, 1, 1, 8'h55, 8'h44, 4, 0, 1, 24'h002000};
        vecs[11] = '{16'hC000, 0, 1, 8'h77, 8'h00, 1, 0, 0, 24'h000000};
        vecs[12] = '{16'h4123, 0, 1, 8'h99, 8'h00, 1, 0, 0, 24'h000000};
        vecs[13] = '{16'h4123, 1, 0, 8'h00, 8'h66, 2, 0, 1, 24'h000123};
        vecs[14] = '{16'h6FFF, 0, 1, 8'h81, 8'h00, 1, 0, 0, 24'h000000};
        vecs[15] = '{16'h7FFF, 1, 0, 8'h00, 8'h5C, 6, 2, 1, 24'h103FFF};

        n_reset = 1'b0; bus_address = '0; bus_memory = 1'b0; bus_read = 1'b0; bus_write = 1'b0;
        bus_write_data = '0; psram_busy = 1'b0; psram_rdata = '0; psram_rdata_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b1;
        @(posedge clk); #2;
        for (int g = 0; g < NDUT; g++) begin
            check("reset.n_wait", g, 32'(n_wait[g]), 32'd1);
            check("reset.read_data", g, 32'(rd_data[g]), 32'hFF);
            check("reset.strobes", g, 32'({rd_ready[g], p_rd[g], p_wr[g]}), 32'd0);
            check("reset.address", g, 32'(p_addr[g]), 32'd0);
            check("reset.wdata", g, 32'(p_wdata[g]), 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            access(vecs[i].a, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].rdat,
                   vecs[i].dly, vecs[i].busy_pre, 1'b1, -1);
            check($sformatf("vec%0d.req0", i), 0, 32'(nrd[0] + nwr[0]), 32'(vecs[i].exp_req0));
            if (vecs[i].exp_req0)
                check($sformatf("vec%0d.addr0", i), 0, 32'(req_addr[0]), 32'(vecs[i].exp_addr0));
            verify($sformatf("vec%0d", i), vecs[i].a, vecs[i].rd, vecs[i].wr, vecs[i].wd,
                   vecs[i].rdat, 1'b1, vecs[i].busy_pre);
        end

        for (int i = 0; i < 40; i++) begin
            ra   = {3'($urandom_range(0, 7)), 13'($urandom)};
            kind = $urandom_range(0, 4);
            access(ra, kind <= 1 || kind == 4, kind >= 2, 8'($urandom), 8'($urandom),
                   $urandom_range(1, 6), $urandom_range(0, 3), 1'b1, -1);
            verify($sformatf("rnd%0d", i), ra, kind <= 1 || kind == 4, kind >= 2,
                   bus_write_data, psram_rdata, 1'b1, 0);
        end

        // No response: abort after the timeout, second strobe during WAIT ignored
        access(16'h4000, 1'b1, 1'b0, 8'h00, 8'h00, 1, 0, 1'b0, 20);
        verify("timeout", 16'h4000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 0);
        for (int g = 0; g < NDUT; g++) begin
            check("timeout.not_early", g, 32'(ready_cycle[g] - req_cycle[g] >= TIMEOUT), 32'd1);
            check("timeout.not_late", g, 32'(ready_cycle[g] - req_cycle[g] <= TIMEOUT + 2), 32'd1);
        end

        // Reset asserted while waiting for read data
        @(posedge clk); #1;
        bus_address = 16'h4000; bus_read = 1'b1; bus_write = 1'b0; bus_memory = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(posedge clk); #1; bus_memory = 1'b0; #1;
            if (p_rd[0]) seen = 1;
        end
        bus_read = 1'b0;
        check("rst.rd_issued", 0, 32'(seen), 32'd1);
        @(posedge clk); @(posedge clk); #2;
        n_reset = 1'b0; #1;
        for (int g = 0; g < NDUT; g++) begin
            check("rst.n_wait", g, 32'(n_wait[g]), 32'd1);
            check("rst.rd_wr", g, 32'({p_rd[g], p_wr[g]}), 32'd0);
            check("rst.read_data", g, 32'(rd_data[g]), 32'hFF);
        end
        @(posedge clk); #1; n_reset = 1'b1;
        psram_rdata = 8'h5E; psram_rdata_en = 1'b1;
        @(posedge clk); #1; psram_rdata_en = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            for (int g = 0; g < NDUT; g++) if (rd_ready[g] || !n_wait[g]) bad++;
            @(posedge clk); #1;
        end
        check("rst.late_data_ignored", 0, 32'(bad), 32'd0);
        model_reset();
        access(16'h8000, 1'b1, 1'b0, 8'h00, 8'h12, 2, 0, 1'b1, -1);
        check("rst.bank2_restored", 0, 32'(req_addr[0]), 32'h004000);
        verify("post_reset", 16'h8000, 1'b1, 1'b0, 8'h00, 8'h12, 1'b1, 0);

        for (int g = 0; g < NDUT; g++) check("protocol", g, 32'(viol[g]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ip_ascii8_psram_bridge.md
Name: ip_ascii8_psram_bridge

Overview:
- Sits between the MSX 50-pin bus decoder (ip_msxbus) and one channel of ip_psram.
- Implements an ASCII8-style MegaROM mapper: four 8 KB bank registers translate CPU addresses 4000h-BFFFh into 24-bit PSRAM addresses.
- Issues single-byte rd/wr requests to PSRAM and holds the CPU with n_wait until each access completes.
- Returns read data to the bus decoder with a one-cycle ready strobe.

Parameters:
- BASE_ADDR, 24'h000000, PSRAM byte offset added to every mapped address.
- RAM_WRITE_EN, 1'b0, 1 = writes to mapped pages outside the register windows go to PSRAM; 0 = such writes are dropped.
- TIMEOUT, 255, maximum wait cycles for a PSRAM response before the access is aborted.

Ports:
- clk  in  1  system clock, 54 MHz.
- n_reset  in  1  asynchronous, active-low reset.
- bus_address  in  16  CPU address.
- bus_memory  in  1  one-clk strobe: slot-selected memory access.
- bus_read  in  1  access is a read (qualifies bus_memory).
- bus_write  in  1  access is a write (qualifies bus_memory).
- bus_write_data  in  8  CPU write data.
- bus_read_data  out  8  read data for the CPU.
- bus_read_ready  out  1  one-clk strobe: bus_read_data valid.
- n_wait  out  1  active-low CPU wait request.
- psram_rd  out  1  one-clk read request to ip_psram.
- psram_wr  out  1  one-clk write request to ip_psram.
- psram_busy  in  1  ip_psram busy.
- psram_address  out  24  PSRAM byte address.
- psram_wdata  out  8  PSRAM write data.
- psram_rdata  in  8  PSRAM read data.
- psram_rdata_en  in  1  psram_rdata valid strobe.

Behaviour:
- Reset values:
  - bank0..3 = 8'd0, 8'd1, 8'd2, 8'd3.
  - psram_rd = psram_wr = 0.
  - n_wait = 1.
  - bus_read_ready = 0.
  - bus_read_data = 8'hFF.
  - psram_address = 0, psram_wdata = 0.
  - state = IDLE.
- Reset mid-access aborts immediately to these values; there is no pending-request memory.
- Page select: p = bus_address[14:13] - 2 for addresses 4000h-BFFFh (4000h→bank0, 6000h→bank1, 8000h→bank2, A000h→bank3). Addresses outside 4000h-BFFFh are unmapped.
- Mapped address: psram_address = BASE_ADDR + {3'b000, bank[p], bus_address[12:0]}. The addition is 24-bit and wraps modulo 2^24.
- Register windows (write only, no PSRAM access, no wait):
  - 6000h-67FFh → bank0.
  - 6800h-6FFFh → bank1.
  - 7000h-77FFh → bank2.
  - 7800h-7FFFh → bank3.
  - Register update takes effect for accesses strobed on the next clk.
- Commands are accepted only in IDLE. Strobes arriving in any other state are ignored.
- If bus_read and bus_write are both high with bus_memory, the access is treated as a read.
- IDLE:
  - Unmapped read, or bus_memory without read/write: ignored.
  - Mapped read: latch address, go to ISSUE, n_wait = 0 from the next clk.
  - Register-window write: update the bank register, stay in IDLE.
  - Other mapped write with RAM_WRITE_EN = 1: latch address and data, go to ISSUE, n_wait = 0.
  - Other mapped write with RAM_WRITE_EN = 0: ignored.
- ISSUE: wait for psram_busy = 0, then pulse psram_rd or psram_wr for exactly 1 clk. Clear the timeout counter, go to WAIT.
- WAIT, read:
  - On psram_rdata_en: capture psram_rdata into bus_read_data, pulse bus_read_ready for 1 clk in the same cycle n_wait returns to 1, go to IDLE.
- WAIT, write:
  - Ignore psram_busy for the first clk after the request (busy may lag by one cycle).
  - Then, when psram_busy = 0: release n_wait, go to IDLE.
- Timeout: an 8-bit counter runs in WAIT. When it reaches TIMEOUT:
  - Read: bus_read_data = 8'hFF, pulse bus_read_ready.
  - Either access: release n_wait, go to IDLE.
- Timeout applies to WAIT only; ISSUE waits indefinitely on busy.
- psram_rd and psram_wr are never high together and never high for 2 consecutive clks.

Test Plan:
- Reset, read 4000h with psram_rdata_en returning A5h 5 clks after psram_rd → psram_address = 000000h, exactly 1 psram_rd pulse, n_wait low until the bus_read_ready cycle, bus_read_data = A5h.
- Write 3Ch to 7000h, then read 9FFFh → no psram_wr, bank2 = 3Ch, read address = 079FFFh.
- BASE_ADDR = 200000h, bank3 = FFh, read BFFFh → psram_address = 3FFFFFh; bank3 = 0 with BASE_ADDR = FFFFF0h, read A005h → address wraps to FFFFF5h.
- RAM_WRITE_EN = 1, write 5Ah to 8000h with psram_busy already high 3 clks → psram_wr issued only after busy falls, psram_wdata = 5Ah, n_wait released after busy low; with RAM_WRITE_EN = 0 → no psram_wr, n_wait stays 1.
- Read 4000h with no psram_rdata_en → after TIMEOUT clks, bus_read_data = FFh, bus_read_ready pulse, n_wait = 1; a second strobe during WAIT is ignored.
- Assert n_reset low during WAIT → n_wait = 1, psram_rd = psram_wr = 0, banks = 0/1/2/3 immediately; a late psram_rdata_en after reset produces no bus_read_ready.
